d_reg_bank: RTL and testbench

- Multi-channel, parametrised register bank. CHANNELS independent WIDTH-bit storage elements, each with its own load enable and an active-low clear.
- Two load modes:
  - Direct mode: a channel updates on the next clock edge when its enable is high.
  - Shadow mode: writes go to a per-channel shadow register. A single commit pulse transfers all pending shadows to the outputs on the same edge.
- Also reports per-channel pending and value-change status.
- Used as the standard holding/configuration stage in front of datapath blocks that need glitch-free, atomically updated control words.

---
 rtl/d_reg_bank.sv | 64 ++++++
 tb/tb_d_reg_bank.sv | 114 +++++++++++
 2 files changed

// File: rtl/d_reg_bank.sv
// d_reg_bank: multi-channel register bank with direct or shadowed, atomically committed loads
module d_reg_bank #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic                      mode,
  input  logic                      commit,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       pending,
  output logic                      commit_done,
  output logic [CHANNELS-1:0]       changed
);
  logic [CHANNELS-1:0][WIDTH-1:0] q_q, q_d, shadow_q, shadow_d;
  logic [CHANNELS-1:0] pending_q, pending_d, changed_q, changed_d;
  logic commit_done_q, commit_done_d;
  always_comb begin
    q_d = q_q;
    shadow_d = shadow_q;
    pending_d = pending_q;
    changed_d = '0;
    commit_done_d = mode & commit;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!mode) begin
        if (en[i]) q_d[i] = d[i*WIDTH +: WIDTH];
        pending_d[i] = 1'b0;
      end else begin
        // commit moves the pre-edge shadow; a same-edge write refills it and stays pending
        if (commit && pending_q[i]) begin
          q_d[i] = shadow_q[i];
          pending_d[i] = 1'b0;
        end
        if (en[i]) begin
          shadow_d[i] = d[i*WIDTH +: WIDTH];
          pending_d[i] = 1'b1;
        end
      end
      changed_d[i] = q_d[i] != q_q[i];
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      q_q <= {CHANNELS{RST_VAL}};
      shadow_q <= {CHANNELS{RST_VAL}};
      pending_q <= '0;
      changed_q <= '0;
      commit_done_q <= 1'b0;
    end else begin
      q_q <= q_d;
      shadow_q <= shadow_d;
      pending_q <= pending_d;
      changed_q <= changed_d;
      commit_done_q <= commit_done_d;
    end
  end
  assign q = q_q;
  assign pending = pending_q;
  assign changed = changed_q;
  assign commit_done = commit_done_q;
endmodule

// File: tb/tb_d_reg_bank.sv
// tb_d_reg_bank: directed test-plan scenarios plus random traffic against an array-based reference model
module tb_d_reg_bank;
  localparam int W = 8;
  localparam int C = 4;
  logic clk = 0;
  logic rstn;
  logic [C-1:0] en;
  logic [C*W-1:0] d;
  logic mode, commit;
  logic [C*W-1:0] q;
  logic [C-1:0] pending, changed;
  logic commit_done;
  int n_chk = 0, n_fail = 0;
  logic [W-1:0] m_q[C], m_sh[C];
  bit m_pend[C], m_chg[C];
  bit m_cd;
  d_reg_bank #(.WIDTH(W), .CHANNELS(C), .RST_VAL(8'h00)) dut (
    .clk(clk), .rstn(rstn), .en(en), .d(d), .mode(mode), .commit(commit),
    .q(q), .pending(pending), .commit_done(commit_done), .changed(changed)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic logic [C*W-1:0] m_qv();
    logic [C*W-1:0] v;
    for (int i = 0; i < C; i++) v[i*W +: W] = m_q[i];
    return v;
  endfunction
  function automatic logic [C-1:0] m_bits(input bit which);
    logic [C-1:0] v;
    for (int i = 0; i < C; i++) v[i] = which ? m_chg[i] : m_pend[i];
    return v;
  endfunction
  task automatic model(input logic r, input logic [C-1:0] e, input logic [C*W-1:0] dd, input logic m, input logic c);
    logic [W-1:0] nq[C];
    if (!r) begin
      for (int i = 0; i < C; i++) begin
        m_q[i] = '0; m_sh[i] = '0; m_pend[i] = 0; m_chg[i] = 0;
      end
      m_cd = 0;
      return;
    end
    for (int i = 0; i < C; i++)
      nq[i] = !m ? (e[i] ? dd[i*W +: W] : m_q[i]) : ((c && m_pend[i]) ? m_sh[i] : m_q[i]);
    for (int i = 0; i < C; i++) begin
      m_chg[i] = nq[i] != m_q[i];
      m_q[i] = nq[i];
      m_pend[i] = m && (e[i] || (m_pend[i] && !c));
      if (m && e[i]) m_sh[i] = dd[i*W +: W];
    end
    m_cd = m && c;
  endtask
  task automatic step(input logic r, input logic [C-1:0] e, input logic [C*W-1:0] dd, input logic m, input logic c);
    rstn = r; en = e; d = dd; mode = m; commit = c;
    @(posedge clk);
    model(r, e, dd, m, c);
    #1;
    check("q", q, m_qv());
    check("pending", pending, m_bits(0));
    check("changed", changed, m_bits(1));
    check("commit_done", commit_done, m_cd);
  endtask
  initial begin
    step(0, 4'hF, 32'hFFFFFFFF, 1, 1);
    step(0, 4'hF, 32'hFFFFFFFF, 1, 1);
    check("rst_q", q, 32'h0);
    check("rst_pend", pending, 4'h0);
    step(1, 4'b0101, 32'h44332211, 0, 0);
    check("dir_q", q, 32'h00330011);
    check("dir_chg", changed, 4'b0101);
    step(1, 4'b0101, 32'h44332211, 0, 0);
    check("dir_rpt_chg", changed, 4'b0000);
    step(1, 4'b0001, 32'h000000A5, 1, 0);
    step(1, 4'b0000, 32'h0, 1, 0);
    step(1, 4'b1000, 32'h5A000000, 1, 0);
    step(1, 4'b0000, 32'h0, 1, 0);
    check("sh_pend", pending, 4'b1001);
    check("sh_q_hold", q, 32'h00330011);
    step(1, 4'b0000, 32'h0, 1, 1);
    check("cm_q", q, 32'h5A3300A5);
    check("cm_done", commit_done, 1'b1);
    check("cm_chg", changed, 4'b1001);
    step(1, 4'b0000, 32'h0, 1, 0);
    check("cm_done_low", commit_done, 1'b0);
    step(1, 4'b0010, 32'h00001000, 1, 0);
    step(1, 4'b0010, 32'h00002000, 1, 1);
    check("col_q", q, 32'h5A3310A5);
    check("col_pend", pending, 4'b0010);
    step(1, 4'b0000, 32'h0, 1, 1);
    check("col2_q", q, 32'h5A3320A5);
    check("col2_pend", pending, 4'b0000);
    step(1, 4'b0010, 32'h00007700, 1, 0);
    step(1, 4'b0000, 32'h0, 0, 0);
    check("abort_pend", pending, 4'b0000);
    step(1, 4'b0000, 32'h0, 1, 1);
    check("abort_q", q, 32'h5A3320A5);
    check("abort_done", commit_done, 1'b1);
    step(1, 4'hF, 32'h12345678, 1, 0);
    check("mid_pend", pending, 4'hF);
    step(0, 4'h0, 32'h0, 1, 1);
    check("mid_q", q, 32'h0);
    check("mid_pend0", pending, 4'h0);
    check("mid_done0", commit_done, 1'b0);
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 31) != 0, 4'($urandom), 32'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
